// File: rtl/ahb_nport_arbiter_pkg.sv
// Shared AHB5 encodings for the N-port arbiter.
// Imported by the arbiter RTL and its bench.
package ahb_nport_arbiter_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam int HPROT_DATA  = 0;
   localparam int HPROT_PRIV  = 1;
   localparam int HPROT_BUF   = 2;
   localparam int HPROT_CACHE = 3;

endpackage

// File: rtl/ahb_nport_arbiter_if.sv
// Requester-side and AHB5 manager-side signal bundle of the arbiter.
// The master modport is the arbiter; slave is the surrounding system.
interface ahb_nport_arbiter_if #(
   parameter int N_PORTS = 3,
   parameter int W_ADDR  = 32,
   parameter int W_DATA  = 32
);

   logic [N_PORTS-1:0]        src_req;
   logic [N_PORTS*W_ADDR-1:0] src_haddr;
   logic [N_PORTS-1:0]        src_hwrite;
   logic [N_PORTS-1:0]        src_hexcl;
   logic [N_PORTS*3-1:0]      src_hsize;
   logic [N_PORTS*4-1:0]      src_hprot;
   logic [N_PORTS*8-1:0]      src_hmaster;
   logic [N_PORTS*W_DATA-1:0] src_hwdata;
   logic [N_PORTS-1:0]        src_aph_ready;
   logic [N_PORTS-1:0]        src_dph_ready;
   logic [N_PORTS-1:0]        src_dph_err;
   logic [N_PORTS-1:0]        src_dph_exokay;
   logic [W_DATA-1:0]         src_hrdata;

   logic [W_ADDR-1:0]         haddr;
   logic                      hwrite;
   logic [1:0]                htrans;
   logic [2:0]                hsize;
   logic [3:0]                hprot;
   logic                      hexcl;
   logic [7:0]                hmaster;
   logic [W_DATA-1:0]         hwdata;
   logic [2:0]                hburst;
   logic                      hmastlock;
   logic                      hready;
   logic                      hresp;
   logic                      hexokay;
   logic [W_DATA-1:0]         hrdata;

   modport master (
      input  src_req, src_haddr, src_hwrite, src_hexcl,
      input  src_hsize, src_hprot, src_hmaster, src_hwdata,
      output src_aph_ready, src_dph_ready, src_dph_err,
      output src_dph_exokay, src_hrdata,
      output haddr, hwrite, htrans, hsize, hprot, hexcl,
      output hmaster, hwdata, hburst, hmastlock,
      input  hready, hresp, hexokay, hrdata
   );

   modport slave (
      output src_req, src_haddr, src_hwrite, src_hexcl,
      output src_hsize, src_hprot, src_hmaster, src_hwdata,
      input  src_aph_ready, src_dph_ready, src_dph_err,
      input  src_dph_exokay, src_hrdata,
      input  haddr, hwrite, htrans, hsize, hprot, hexcl,
      input  hmaster, hwdata, hburst, hmastlock,
      output hready, hresp, hexokay, hrdata
   );

endinterface

// File: rtl/ahb_arb_prio_pick.sv
// Lowest-index one-hot picker over an N-wide request vector.
// Isolates the least significant set bit with two's-complement masking.
module ahb_arb_prio_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] i_vec,
   output logic [N-1:0] o_gnt,
   output logic         o_any
);

   assign o_gnt = i_vec & (~i_vec + N'(1));
   assign o_any = |i_vec;

endmodule

// File: rtl/ahb_nport_arbiter.sv
// N-requester to single AHB5 manager arbiter: static priority with
// per-port starvation boost, grant hold while the address phase stalls.
module ahb_nport_arbiter
   import ahb_nport_arbiter_pkg::*;
#(
   parameter int N_PORTS      = 3,
   parameter int W_ADDR       = 32,
   parameter int W_DATA       = 32,
   parameter int W_STARVE     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   ahb_nport_arbiter_if.master bus
);

   localparam logic [W_STARVE-1:0] LIMIT = W_STARVE'(STARVE_LIMIT);

   logic                             r_hold;
   logic [N_PORTS-1:0]               r_gnt_prev;
   logic [N_PORTS-1:0]               r_own;
   logic [N_PORTS-1:0][W_STARVE-1:0] r_cnt;

   logic [N_PORTS-1:0] w_panic;
   logic [N_PORTS-1:0] w_preq;
   logic [N_PORTS-1:0] w_pick_panic;
   logic [N_PORTS-1:0] w_pick_req;
   logic [N_PORTS-1:0] w_gnt;
   logic [N_PORTS-1:0] w_aph;
   logic               w_any_panic;
   logic               w_any_req;

   always_comb begin
      w_panic = '0;
      for (int k = 0; k < N_PORTS; k++)
         w_panic[k] = (r_cnt[k] == LIMIT);
   end

   assign w_preq = w_panic & bus.src_req;

   ahb_arb_prio_pick #(.N(N_PORTS)) u_pick_panic (
      .i_vec (w_preq),
      .o_gnt (w_pick_panic),
      .o_any (w_any_panic)
   );

   ahb_arb_prio_pick #(.N(N_PORTS)) u_pick_req (
      .i_vec (bus.src_req),
      .o_gnt (w_pick_req),
      .o_any (w_any_req)
   );

   always_comb begin
      w_gnt = '0;
      if (r_hold)
         w_gnt = r_gnt_prev;
      else if (w_any_panic)
         w_gnt = w_pick_panic;
      else if (w_any_req)
         w_gnt = w_pick_req;
   end

   assign w_aph = w_gnt & {N_PORTS{bus.hready}};

   // With no grant the bus idles but still carries port 0's ID.
   always_comb begin
      bus.haddr   = '0;
      bus.hwrite  = 1'b0;
      bus.hsize   = '0;
      bus.hprot   = '0;
      bus.hexcl   = 1'b0;
      bus.hmaster = bus.src_hmaster[7:0];
      bus.htrans  = HTRANS_IDLE;
      for (int k = 0; k < N_PORTS; k++) begin
         if (w_gnt[k]) begin
            bus.haddr   = bus.src_haddr[k*W_ADDR +: W_ADDR];
            bus.hwrite  = bus.src_hwrite[k];
            bus.hsize   = bus.src_hsize[k*3 +: 3];
            bus.hprot   = bus.src_hprot[k*4 +: 4];
            bus.hexcl   = bus.src_hexcl[k];
            bus.hmaster = bus.src_hmaster[k*8 +: 8];
            bus.htrans  = HTRANS_NSEQ;
         end
      end
   end

   always_comb begin
      bus.hwdata = '0;
      for (int k = 0; k < N_PORTS; k++)
         if (r_own[k])
            bus.hwdata = bus.src_hwdata[k*W_DATA +: W_DATA];
   end

   assign bus.src_aph_ready  = w_aph;
   assign bus.src_dph_ready  = r_own & {N_PORTS{bus.hready}};
   assign bus.src_dph_err    = r_own & {N_PORTS{bus.hresp}};
   assign bus.src_dph_exokay = r_own & {N_PORTS{bus.hexokay}};
   assign bus.src_hrdata     = bus.hrdata;
   assign bus.hburst         = HBURST_SINGLE;
   assign bus.hmastlock      = 1'b0;

   // An error response releases the hold so its second cycle re-arbitrates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold     <= 1'b0;
         r_gnt_prev <= '0;
         r_own      <= '0;
      end else begin
         r_hold     <= bus.htrans[1] & ~bus.hready & ~bus.hresp;
         r_gnt_prev <= w_gnt;
         if (bus.hready)
            r_own <= w_gnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         for (int k = 0; k < N_PORTS; k++) begin
            if (w_aph[k] || !bus.src_req[k])
               r_cnt[k] <= '0;
            else if (r_cnt[k] != LIMIT)
               r_cnt[k] <= r_cnt[k] + W_STARVE'(1);
         end
      end
   end

endmodule

// File: tb/tb_ahb_nport_arbiter.sv
// Directed bench for ahb_nport_arbiter: data-phase scoreboard plus
// immediate checks on address-phase and response outputs.
module tb_ahb_nport_arbiter;
   import ahb_nport_arbiter_pkg::*;

   typedef struct {
      int          port;
      logic [31:0] wd;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   exp_t sb[$];

   ahb_nport_arbiter_if #(.N_PORTS(3), .W_ADDR(32), .W_DATA(32)) bus ();

   ahb_nport_arbiter #(
      .N_PORTS(3), .W_ADDR(32), .W_DATA(32),
      .W_STARVE(4), .STARVE_LIMIT(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic setp(input int k, input logic [31:0] a, input logic w,
                       input logic x, input logic [7:0] id,
                       input logic [31:0] wd);
      bus.src_haddr[k*32 +: 32]  = a;
      bus.src_hwrite[k]          = w;
      bus.src_hexcl[k]           = x;
      bus.src_hsize[k*3 +: 3]    = 3'd2;
      bus.src_hprot[k*4 +: 4]    = 4'b0011;
      bus.src_hmaster[k*8 +: 8]  = id;
      bus.src_hwdata[k*32 +: 32] = wd;
   endtask

   task automatic push(input int p, input logic [31:0] wd);
      exp_t e;
      e.port = p;
      e.wd   = wd;
      sb.push_back(e);
   endtask

   // Completes any data phase against the scoreboard, then one clock.
   task automatic adv();
      exp_t e;
      if (bus.src_dph_ready !== 3'b000) begin
         chk("sb_avail", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("dph_own", 64'(bus.src_dph_ready), 64'(3'b001 << e.port));
            chk("hwdata", 64'(bus.hwdata), 64'(e.wd));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.src_req     = '0;
      bus.src_haddr   = '0;
      bus.src_hwrite  = '0;
      bus.src_hexcl   = '0;
      bus.src_hsize   = '0;
      bus.src_hprot   = '0;
      bus.src_hmaster = '0;
      bus.src_hwdata  = '0;
      bus.hready      = 1'b1;
      bus.hresp       = 1'b0;
      bus.hexokay     = 1'b0;
      bus.hrdata      = 32'hCAFE_F00D;
      setp(0, 32'h0000_1000, 1'b0, 1'b0, 8'h10, 32'hA0A0_0000);
      setp(1, 32'h0000_1100, 1'b1, 1'b0, 8'h11, 32'hB1B1_0001);
      setp(2, 32'h2000_0000, 1'b1, 1'b0, 8'h22, 32'hC2C2_0000);

      #1;
      chk("rst_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
      chk("rst_haddr", 64'(bus.haddr), 64'd0);
      chk("rst_hsize_hprot", 64'({bus.hsize, bus.hprot}), 64'd0);
      chk("rst_hwrite_hexcl", 64'({bus.hwrite, bus.hexcl}), 64'd0);
      chk("rst_hmaster", 64'(bus.hmaster), 64'h10);
      chk("rst_hwdata", 64'(bus.hwdata), 64'd0);
      chk("rst_src_hs", 64'({bus.src_aph_ready, bus.src_dph_ready,
          bus.src_dph_err, bus.src_dph_exokay}), 64'd0);
      chk("hrdata_bcast", 64'(bus.src_hrdata), 64'hCAFE_F00D);
      chk("hburst_lock", 64'({bus.hburst, bus.hmastlock}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Port 2 alone, back-to-back writes
      for (int i = 0; i < 4; i++) begin
         setp(2, 32'h2000_0000 + 32'(4 * i), 1'b1, 1'b0, 8'h22,
              32'hC2C2_0000 + 32'(i - 1));
         bus.src_req = 3'b100;
         push(2, 32'hC2C2_0000 + 32'(i));
         #1;
         chk("t1_htrans", 64'(bus.htrans), 64'(HTRANS_NSEQ));
         chk("t1_haddr", 64'(bus.haddr), 64'(32'h2000_0000 + 32'(4 * i)));
         chk("t1_hmaster", 64'(bus.hmaster), 64'h22);
         chk("t1_aph", 64'(bus.src_aph_ready), 64'b100);
         if (i == 0)
            chk("t1_size_prot", 64'({bus.hsize, bus.hprot}), 64'h23);
         adv();
      end
      setp(2, 32'h2000_000C, 1'b1, 1'b0, 8'h22, 32'hC2C2_0003);
      bus.src_req = 3'b000;
      #1;
      chk("t1_idle", 64'(bus.htrans), 64'(HTRANS_IDLE));
      adv();
      chk("t1_dph_done", 64'(bus.src_dph_ready), 64'd0);

      // Ports 0 and 1 contend during a 3-cycle stall
      bus.src_req = 3'b011;
      bus.hready  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t2_hold_addr", 64'(bus.haddr), 64'h1000);
         chk("t2_hold_id", 64'(bus.hmaster), 64'h10);
         chk("t2_aph_stall", 64'(bus.src_aph_ready), 64'd0);
         adv();
      end
      bus.hready = 1'b1;
      #1;
      chk("t2_release", 64'(bus.haddr), 64'h1000);
      chk("t2_aph0", 64'(bus.src_aph_ready), 64'b001);
      push(0, 32'hA0A0_0000);
      adv();
      bus.src_req = 3'b010;
      #1;
      chk("t2_switch", 64'(bus.haddr), 64'h1100);
      chk("t2_aph1", 64'(bus.src_aph_ready), 64'b010);
      push(1, 32'hB1B1_0001);
      adv();
      bus.src_req = 3'b000;
      #1;
      adv();

      // Port 2 starves behind port 0 until it panics
      for (int i = 1; i <= 10; i++) begin
         bus.src_req = 3'b101;
         #1;
         if (i == 9) begin
            chk("t3_boost", 64'(bus.src_aph_ready), 64'b100);
            chk("t3_boost_addr", 64'(bus.haddr), 64'h2000_000C);
            push(2, 32'hC2C2_0003);
         end else begin
            chk("t3_prio", 64'(bus.src_aph_ready), 64'b001);
            push(0, 32'hA0A0_0000);
         end
         adv();
      end
      bus.src_req = 3'b000;
      #1;
      chk("t3_idle", 64'(bus.src_aph_ready), 64'd0);
      adv();

      // Two-cycle error response on a port 1 data phase
      setp(1, 32'h0000_1104, 1'b1, 1'b0, 8'h11, 32'hB1B1_0002);
      bus.src_req = 3'b010;
      #1;
      chk("t4_aph1", 64'(bus.src_aph_ready), 64'b010);
      push(1, 32'hB1B1_0002);
      adv();
      bus.src_haddr[32 +: 32] = 32'h0000_1108;
      bus.hresp  = 1'b1;
      bus.hready = 1'b0;
      #1;
      chk("t4_err_c1", 64'(bus.src_dph_err), 64'b010);
      chk("t4_chase_addr", 64'(bus.haddr), 64'h1108);
      chk("t4_aph_c1", 64'(bus.src_aph_ready), 64'd0);
      adv();
      bus.hready  = 1'b1;
      bus.src_req = 3'b011;
      #1;
      chk("t4_err_c2", 64'(bus.src_dph_err), 64'b010);
      chk("t4_regrant", 64'(bus.src_aph_ready), 64'b001);
      chk("t4_regrant_addr", 64'(bus.haddr), 64'h1000);
      push(0, 32'hA0A0_0000);
      adv();
      bus.hresp   = 1'b0;
      bus.src_req = 3'b000;
      #1;
      chk("t4_err_clear", 64'(bus.src_dph_err), 64'd0);
      adv();

      // Exclusive write from port 1
      setp(1, 32'h0000_1200, 1'b1, 1'b1, 8'h11, 32'hDEAD_BEEF);
      bus.src_req = 3'b010;
      #1;
      chk("t5_hexcl", 64'({bus.hexcl, bus.hwrite}), 64'b11);
      chk("t5_aph", 64'(bus.src_aph_ready), 64'b010);
      push(1, 32'hDEAD_BEEF);
      adv();
      bus.src_req = 3'b000;
      bus.hexokay = 1'b1;
      #1;
      chk("t5_hexcl_idle", 64'(bus.hexcl), 64'd0);
      chk("t5_idle_id", 64'(bus.hmaster), 64'h10);
      chk("t5_exokay", 64'(bus.src_dph_exokay), 64'b010);
      adv();
      chk("t5_exokay_gone", 64'(bus.src_dph_exokay), 64'd0);
      bus.hexokay = 1'b0;

      // Reset during a stalled port 2 address phase
      setp(2, 32'h2000_0100, 1'b1, 1'b0, 8'h22, 32'hC2C2_0100);
      bus.src_req = 3'b100;
      #1;
      chk("t6_aph", 64'(bus.src_aph_ready), 64'b100);
      push(2, 32'hC2C2_0100);
      adv();
      bus.src_haddr[64 +: 32] = 32'h2000_0104;
      bus.hready = 1'b0;
      #1;
      chk("t6_stall_addr", 64'(bus.haddr), 64'h2000_0104);
      chk("t6_stall_dph", 64'(bus.src_dph_ready), 64'd0);
      adv();
      rst_n       = 1'b0;
      bus.src_req = 3'b000;
      bus.hready  = 1'b1;
      bus.hresp   = 1'b1;
      bus.hexokay = 1'b1;
      #1;
      chk("t6_rst_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
      chk("t6_rst_dph", 64'({bus.src_dph_ready, bus.src_dph_err,
          bus.src_dph_exokay}), 64'd0);
      sb.delete();
      adv();
      chk("t6_rst_next", 64'(bus.htrans), 64'(HTRANS_IDLE));
      chk("t6_rst_next_dph", 64'({bus.src_dph_ready, bus.src_dph_err,
          bus.src_dph_exokay}), 64'd0);
      bus.hresp   = 1'b0;
      bus.hexokay = 1'b0;
      rst_n       = 1'b1;
      bus.src_req = 3'b001;
      #1;
      chk("t6_post_aph", 64'(bus.src_aph_ready), 64'b001);
      chk("t6_post_addr", 64'(bus.haddr), 64'h1000);
      push(0, 32'hA0A0_0000);
      adv();
      bus.src_req = 3'b000;
      #1;
      adv();
      chk("sb_drain", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
